// File: rtl/servo_cmd_if.sv
// Width command channel into the servo ramp sequencer: valid/ready handshake with a 13-bit requested width.
`timescale 1ns/1ps
interface servo_cmd_if;
    logic        cmd_valid;
    logic [12:0] cmd_width;
    logic        cmd_ready;

    modport master (output cmd_valid, output cmd_width, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_width, output cmd_ready);
endinterface

// File: rtl/servo_ramp_ctrl.sv
// Clamps width commands to the servo range and slews the PWM width toward the target by at most STEP per frame.
// One-cycle done pulse after the final step; commands are held off (ready low) while a ramp is in progress.
`timescale 1ns/1ps
module servo_ramp_ctrl #(
    parameter int CLK_DIV     = 1000,
    parameter int FRAME_TICKS = 2001,
    parameter int MIN_W       = 50,
    parameter int MAX_W       = 250,
    parameter int STEP        = 5,
    parameter int INIT_W      = 150
) (
    input  logic        i_clk,
    input  logic        i_rst,
    servo_cmd_if.slave  cmd,
    input  logic        i_stop,
    output logic [12:0] o_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_frame_tick
);
    localparam int FRAME_LEN = CLK_DIV * FRAME_TICKS;
    localparam int CW        = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [12:0] target_q, target_d;
    logic [12:0] data_q, data_d;
    logic        done_q, done_d;
    logic [12:0] clamped;
    logic [12:0] diff;
    logic        accept;

    assign o_frame_tick  = (frame_cnt_q == FRAME_LAST);
    assign frame_cnt_d   = o_frame_tick ? '0 : frame_cnt_q + 1'b1;
    assign cmd.cmd_ready = (state_q == IDLE) && !i_rst;
    assign accept        = cmd.cmd_valid && (state_q == IDLE) && !i_rst;
    assign o_busy        = (state_q == RAMP);
    assign o_done        = done_q;
    assign o_data        = data_q;

    always_comb begin
        clamped = cmd.cmd_width;
        if (cmd.cmd_width < 13'(MIN_W)) begin
            clamped = 13'(MIN_W);
        end else if (cmd.cmd_width > 13'(MAX_W)) begin
            clamped = 13'(MAX_W);
        end
    end

    // Order the operands before subtracting so the distance never wraps.
    assign diff = (target_q >= data_q) ? (target_q - data_q) : (data_q - target_q);

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        data_d   = data_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = clamped;
                    if (clamped == data_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (i_stop) begin
                    target_d = data_q;
                    state_d  = IDLE;
                end else if (o_frame_tick) begin
                    if (diff <= 13'(STEP)) begin
                        data_d  = target_q;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (target_q > data_q) begin
                        data_d = data_q + 13'(STEP);
                    end else begin
                        data_d = data_q - 13'(STEP);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            target_q    <= 13'(INIT_W);
            data_q      <= 13'(INIT_W);
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            target_q    <= target_d;
            data_q      <= data_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a 10-cycle frame (CLK_DIV=2, FRAME_TICKS=5).
`timescale 1ns/1ps
module tb_servo_ramp_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic [12:0] o_data;
    logic        o_busy;
    logic        o_done;
    logic        o_frame_tick;
    int          checks = 0;
    int          errors = 0;

    servo_cmd_if cmd_if ();

    servo_ramp_ctrl #(
        .CLK_DIV(2), .FRAME_TICKS(5), .MIN_W(50), .MAX_W(250), .STEP(5), .INIT_W(150)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .cmd          (cmd_if.slave),
        .i_stop       (stop),
        .o_data       (o_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_frame_tick (o_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle where o_frame_tick is high (possibly the current one).
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_frame_tick) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stop = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_width = 13'd0;
        repeat (3) cyc();
        checks++; if (o_data !== 13'd150) begin errors++; $display("FAIL reset_data: got %0d expected 150", o_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", o_done); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b expected 0", cmd_if.cmd_ready); end
        checks++; if (o_frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", o_frame_tick); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", cmd_if.cmd_ready); end
        for (int n = 1; n <= 20; n++) begin
            cyc();
            checks++;
            if (o_frame_tick !== ((n % 10) == 9)) begin
                errors++; $display("FAIL tick_period: cycle %0d got %b expected %b", n, o_frame_tick, ((n % 10) == 9));
            end
        end
    endtask

    task automatic test_up_ramp();
        bit ok;
        int exp_up[3];
        int cur;
        exp_up = '{155, 160, 162};
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd162;
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL up_ready: got %b expected 1", cmd_if.cmd_ready); end
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL up_busy_rise: got %b expected 1", o_busy); end
        checks++; if (o_data !== 13'd150) begin errors++; $display("FAIL up_no_early_step: got %0d expected 150", o_data); end
        for (int k = 0; k < 3; k++) begin
            wait_tick(ok);
            checks++; if (!ok) begin errors++; $display("FAIL up_tick_timeout: got none expected tick"); end
            cyc();
            checks++; if (o_data !== 13'(exp_up[k])) begin errors++; $display("FAIL up_step: got %0d expected %0d", o_data, exp_up[k]); end
            checks++; if (o_done !== (k == 2)) begin errors++; $display("FAIL up_done: step %0d got %b expected %b", k, o_done, (k == 2)); end
            checks++; if (o_busy !== (k != 2)) begin errors++; $display("FAIL up_busy: step %0d got %b expected %b", k, o_busy, (k != 2)); end
        end
        cyc();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL up_done_pulse: got %b expected 0", o_done); end
        // Walk back down to centre for the following scenarios.
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd150;
        cyc();
        cmd_if.cmd_valid = 1'b0;
        cur = 162;
        for (int k = 1; k <= 3; k++) begin
            wait_tick(ok);
            checks++; if (!ok) begin errors++; $display("FAIL down_tick_timeout: got none expected tick"); end
            cyc();
            cur = (cur - 150 > 5) ? cur - 5 : 150;
            checks++; if (o_data !== 13'(cur)) begin errors++; $display("FAIL down_step: got %0d expected %0d", o_data, cur); end
        end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL down_done: got %b expected 1", o_done); end
    endtask

    task automatic test_same_value();
        cyc();
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd150;
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL same_done: got %b expected 1", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL same_busy: got %b expected 0", o_busy); end
        checks++; if (o_data !== 13'd150) begin errors++; $display("FAIL same_data: got %0d expected 150", o_data); end
        cyc();
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL same_done_pulse: got %b expected 0", o_done); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL same_busy_after: got %b expected 0", o_busy); end
    endtask

    task automatic test_clamp();
        bit ok;
        int cur;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd20;
        cyc();
        cmd_if.cmd_valid = 1'b0;
        cur = 150;
        for (int k = 1; k <= 20; k++) begin
            wait_tick(ok);
            checks++; if (!ok) begin errors++; $display("FAIL clamp_lo_timeout: got none expected tick"); end
            cyc();
            cur = cur - 5;
            checks++; if (o_data !== 13'(cur)) begin errors++; $display("FAIL clamp_lo_step: got %0d expected %0d", o_data, cur); end
            checks++; if (o_data < 13'd50 || o_data > 13'd250) begin errors++; $display("FAIL clamp_lo_range: got %0d expected 50..250", o_data); end
            checks++; if (o_done !== (k == 20)) begin errors++; $display("FAIL clamp_lo_done: tick %0d got %b expected %b", k, o_done, (k == 20)); end
        end
        cyc();
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd8191;
        cyc();
        cmd_if.cmd_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            wait_tick(ok);
            checks++; if (!ok) begin errors++; $display("FAIL clamp_hi_timeout: got none expected tick"); end
            cyc();
            cur = cur + 5;
            checks++; if (o_data !== 13'(cur)) begin errors++; $display("FAIL clamp_hi_step: got %0d expected %0d", o_data, cur); end
            checks++; if (o_done !== (k == 40)) begin errors++; $display("FAIL clamp_hi_done: tick %0d got %b expected %b", k, o_done, (k == 40)); end
        end
        checks++; if (o_data !== 13'd250) begin errors++; $display("FAIL clamp_hi_final: got %0d expected 250", o_data); end
    endtask

    task automatic test_backpressure_stop();
        bit ok;
        int cur;
        cyc();
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd50;
        cyc();
        cmd_if.cmd_width = 13'd200;
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", cmd_if.cmd_ready); end
        for (int k = 1; k <= 3; k++) begin
            wait_tick(ok);
            checks++; if (!ok) begin errors++; $display("FAIL bp_tick_timeout: got none expected tick"); end
            cyc();
            checks++; if (o_data !== 13'(250 - 5 * k)) begin errors++; $display("FAIL bp_step: got %0d expected %0d", o_data, 250 - 5 * k); end
            checks++; if (cmd_if.cmd_ready !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL bp_held: ready %b busy %b expected ready 0 busy 1", cmd_if.cmd_ready, o_busy); end
        end
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stop_tick_timeout: got none expected tick"); end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++; if (o_data !== 13'd235) begin errors++; $display("FAIL stop_frozen: got %0d expected 235", o_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stop_idle: got busy %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL stop_no_done: got %b expected 0", o_done); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL stop_ready: got %b expected 1", cmd_if.cmd_ready); end
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_done !== 1'b0 || o_data !== 13'd235) begin
            errors++; $display("FAIL held_accept: busy %b done %b data %0d expected 1 0 235", o_busy, o_done, o_data);
        end
        cur = 235;
        for (int k = 1; k <= 7; k++) begin
            wait_tick(ok);
            checks++; if (!ok) begin errors++; $display("FAIL held_tick_timeout: got none expected tick"); end
            cyc();
            cur = (cur - 200 > 5) ? cur - 5 : 200;
            checks++; if (o_data !== 13'(cur)) begin errors++; $display("FAIL held_step: got %0d expected %0d", o_data, cur); end
            checks++; if (o_done !== (k == 7)) begin errors++; $display("FAIL held_done: tick %0d got %b expected %b", k, o_done, (k == 7)); end
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit ok;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (o_data !== 13'd150) begin errors++; $display("FAIL rst_centre: got %0d expected 150", o_data); end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd250;
        cyc();
        cmd_if.cmd_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_tick(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rst_tick_timeout: got none expected tick"); end
            cyc();
        end
        checks++; if (o_data !== 13'd175) begin errors++; $display("FAIL rst_pre: got %0d expected 175", o_data); end
        rst = 1'b1;
        cyc();
        checks++; if (o_data !== 13'd150) begin errors++; $display("FAIL rst_mid_data: got %0d expected 150", o_data); end
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || cmd_if.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags: busy %b done %b ready %b expected 0 0 0", o_busy, o_done, cmd_if.cmd_ready);
        end
        rst = 1'b0;
        cyc();
        checks++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_data !== 13'd150 || cmd_if.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_after: busy %b done %b data %0d ready %b expected 0 0 150 1", o_busy, o_done, o_data, cmd_if.cmd_ready);
        end
    endtask

    task automatic test_accept_on_tick();
        bit ok;
        int n;
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL aot_tick_timeout: got none expected tick"); end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_width = 13'd160;
        cyc();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_data !== 13'd150) begin
            errors++; $display("FAIL aot_accept: busy %b data %0d expected 1 150", o_busy, o_data);
        end
        n = 0;
        while (!o_frame_tick && n < 20) begin
            cyc();
            n++;
        end
        checks++; if (n !== 9) begin errors++; $display("FAIL aot_next_tick: got %0d cycles expected 9", n); end
        checks++; if (o_data !== 13'd150) begin errors++; $display("FAIL aot_no_step: got %0d expected 150", o_data); end
        cyc();
        checks++; if (o_data !== 13'd155) begin errors++; $display("FAIL aot_first_step: got %0d expected 155", o_data); end
        wait_tick(ok);
        cyc();
        checks++; if (o_data !== 13'd160 || o_done !== 1'b1) begin
            errors++; $display("FAIL aot_final: data %0d done %b expected 160 1", o_data, o_done);
        end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_same_value();
        test_clamp();
        test_backpressure_stop();
        test_reset_mid_ramp();
        test_accept_on_tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
